rtc_timekeeper: RTL

//  Parametrised time-of-day counter with an internal tick prescaler and run/set/alarm-set modes.

---
 rtl/rtc_pkg.sv | 35 +++
 rtl/wrap_counter.sv | 51 +++++
 rtl/rtc_timekeeper.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
// rtc_pkg : shared mode encoding and field limits for the RTC timekeeper
// Rev 1.0
// ============================================================================
package rtc_pkg;

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    SET_H = 3'd1,
    SET_M = 3'd2,
    SET_S = 3'd3,
    AL_H  = 3'd4,
    AL_M  = 3'd5
  } mode_t;

  localparam int HOURS_MAX = 23;
  localparam int MIN_MAX   = 59;
  localparam int SEC_MAX   = 59;

  // Unused encodings fall back to RUN so a corrupted mode register self-recovers.
  function automatic mode_t mode_next(input mode_t m);
    case (m)
      RUN:     return SET_H;
      SET_H:   return SET_M;
      SET_M:   return SET_S;
      SET_S:   return AL_H;
      AL_H:    return AL_M;
      AL_M:    return RUN;
      default: return RUN;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/wrap_counter.sv
`default_nettype none
// ============================================================================
// wrap_counter : mod-(MAX+1) up/down counter with clear, load and wrap carry
// Rev 1.0
// ============================================================================
module wrap_counter #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load_en,
  input  logic [W-1:0] load_val,
  input  logic         up,
  input  logic         down,
  output logic [W-1:0] count,
  output logic         carry_out
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load_en) begin
      count_d = load_val;
    end else if (up && !down) begin
      count_d = (count_q == MAX_V) ? '0 : count_q + 1'b1;
    end else if (down && !up) begin
      count_d = (count_q == '0) ? MAX_V : count_q - 1'b1;
    end
  end

  // Carry only on a genuine upward wrap; clear/load take precedence.
  assign carry_out = up && !down && !clear && !load_en && (count_q == MAX_V);
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rtc_timekeeper.sv
`default_nettype none
// ============================================================================
// rtc_timekeeper : time-of-day counter with tick prescaler, set modes and alarm
// Rev 1.0
// ============================================================================
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int FRAC_MAX = 99,
  parameter int FRAC_W   = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  input  logic              mode_adv,
  input  logic              adj_en,
  input  logic              hr12,
  input  logic              alarm_en,
  input  logic              alarm_ack,
  output logic [4:0]        hours,
  output logic [5:0]        minutes,
  output logic [5:0]        seconds,
  output logic [FRAC_W-1:0] frac,
  output logic [4:0]        disp_hours,
  output logic              pm,
  output logic [2:0]        mode,
  output logic [4:0]        alarm_hours,
  output logic [5:0]        alarm_minutes,
  output logic              alarm_hit,
  output logic              alarm_active
);

  localparam int                   PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  mode_t              mode_d, mode_q;
  logic [PRESC_W-1:0] presc_d, presc_q;
  logic               inc_prev_q, dec_prev_q, adv_prev_q;
  logic               alarm_hit_d, alarm_hit_q;
  logic               alarm_active_d, alarm_active_q;

  logic inc_ev, dec_ev, adv_ev;
  logic adj_up, adj_dn;
  logic running, tick;
  logic sel_h, sel_m, sel_s, sel_ah, sel_am;
  logic frac_carry, sec_carry, min_carry, hr_carry, al_h_carry, al_m_carry;
  logic tick_min, tick_hr;
  logic [5:0] min_next;
  logic [4:0] hr_next;
  logic unused_carries;

  assign inc_ev = inc & ~inc_prev_q;
  assign dec_ev = dec & ~dec_prev_q;
  assign adv_ev = mode_adv & ~adv_prev_q;

  // Simultaneous inc and dec events cancel out.
  assign adj_up = adj_en & inc_ev & ~dec_ev;
  assign adj_dn = adj_en & dec_ev & ~inc_ev;

  assign sel_h  = (mode_q == SET_H);
  assign sel_m  = (mode_q == SET_M);
  assign sel_s  = (mode_q == SET_S);
  assign sel_ah = (mode_q == AL_H);
  assign sel_am = (mode_q == AL_M);

  always_comb begin
    mode_d = mode_q;
    if (adv_ev) begin
      mode_d = mode_next(mode_q);
    end
  end

  assign running = !(sel_h || sel_m || sel_s);
  assign tick    = running && (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q;
    if (sel_s && (adj_up || adj_dn)) begin
      presc_d = '0;
    end else if (running) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
  end

  // Tick carries are qualified separately so adjust wraps never ripple upward.
  assign tick_min = frac_carry & sec_carry;
  assign tick_hr  = tick_min & min_carry;

  wrap_counter #(.W(FRAC_W), .MAX(FRAC_MAX)) u_frac (
    .clk       (clk),
    .reset     (reset),
    .clear     (sel_s & (adj_up | adj_dn)),
    .load_en   (1'b0),
    .load_val  ('0),
    .up        (tick),
    .down      (1'b0),
    .count     (frac),
    .carry_out (frac_carry)
  );

  wrap_counter #(.W(6), .MAX(SEC_MAX)) u_sec (
    .clk       (clk),
    .reset     (reset),
    .clear     (1'b0),
    .load_en   (1'b0),
    .load_val  ('0),
    .up        (frac_carry | (sel_s & adj_up)),
    .down      (sel_s & adj_dn),
    .count     (seconds),
    .carry_out (sec_carry)
  );

  wrap_counter #(.W(6), .MAX(MIN_MAX)) u_min (
    .clk       (clk),
    .reset     (reset),
    .clear     (1'b0),
    .load_en   (1'b0),
    .load_val  ('0),
    .up        (tick_min | (sel_m & adj_up)),
    .down      (sel_m & adj_dn),
    .count     (minutes),
    .carry_out (min_carry)
  );

  wrap_counter #(.W(5), .MAX(HOURS_MAX)) u_hr (
    .clk       (clk),
    .reset     (reset),
    .clear     (1'b0),
    .load_en   (1'b0),
    .load_val  ('0),
    .up        (tick_hr | (sel_h & adj_up)),
    .down      (sel_h & adj_dn),
    .count     (hours),
    .carry_out (hr_carry)
  );

  wrap_counter #(.W(5), .MAX(HOURS_MAX)) u_al_hr (
    .clk       (clk),
    .reset     (reset),
    .clear     (1'b0),
    .load_en   (1'b0),
    .load_val  ('0),
    .up        (sel_ah & adj_up),
    .down      (sel_ah & adj_dn),
    .count     (alarm_hours),
    .carry_out (al_h_carry)
  );

  wrap_counter #(.W(6), .MAX(MIN_MAX)) u_al_min (
    .clk       (clk),
    .reset     (reset),
    .clear     (1'b0),
    .load_en   (1'b0),
    .load_val  ('0),
    .up        (sel_am & adj_up),
    .down      (sel_am & adj_dn),
    .count     (alarm_minutes),
    .carry_out (al_m_carry)
  );

  assign unused_carries = hr_carry ^ al_h_carry ^ al_m_carry;

  // Predict the H:M that this tick produces so the hit lines up with the new time.
  always_comb begin
    min_next = min_carry ? 6'd0 : minutes + 6'd1;
    hr_next  = hours;
    if (min_carry) begin
      hr_next = (hours == 5'(HOURS_MAX)) ? 5'd0 : hours + 5'd1;
    end
  end

  always_comb begin
    alarm_hit_d    = alarm_en && tick_min &&
                     (hr_next == alarm_hours) && (min_next == alarm_minutes);
    alarm_active_d = alarm_hit_d | (alarm_active_q & ~alarm_ack);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q         <= RUN;
      presc_q        <= '0;
      inc_prev_q     <= 1'b0;
      dec_prev_q     <= 1'b0;
      adv_prev_q     <= 1'b0;
      alarm_hit_q    <= 1'b0;
      alarm_active_q <= 1'b0;
    end else begin
      mode_q         <= mode_d;
      presc_q        <= presc_d;
      inc_prev_q     <= inc;
      dec_prev_q     <= dec;
      adv_prev_q     <= mode_adv;
      alarm_hit_q    <= alarm_hit_d;
      alarm_active_q <= alarm_active_d;
    end
  end

  always_comb begin
    disp_hours = hours;
    if (hr12) begin
      if (hours == 5'd0) begin
        disp_hours = 5'd12;
      end else if (hours > 5'd12) begin
        disp_hours = hours - 5'd12;
      end
    end
  end

  assign pm           = (hours >= 5'd12);
  assign mode         = mode_q;
  assign alarm_hit    = alarm_hit_q;
  assign alarm_active = alarm_active_q;

endmodule
`default_nettype wire
